ascon_decrypt_fsm: RTL and testbench
====================================

Name: ascon_decrypt_fsm

Overview:
Control FSM for the ASCON-128 decryption datapath. It is the receive-side counterpart of the encryption controller and drives the same state-register and XOR enables. It sequences initialization, one associated-data block, NB_CT ciphertext blocks with plaintext release and state replacement, and finalization with tag comparison. It owns its own round and block counters and applies a valid/ready handshake to each incoming block.

Parameters:
NB_CT, 3, ciphertext blocks per message (>=1); the last block is always presented padded by the datapath.
ROUNDS_A, 12, rounds of p^a (init/final).
ROUNDS_B, 6, rounds of p^b (AD/CT blocks).
CNT_W, 4, width of round/block counters.

Ports:
clock_i  in  1  clock
resetb_i  in  1  async active-low reset
start_i  in  1  begin message; sampled in IDLE or DONE
abort_i  in  1  sync abort to IDLE; wins over start_i
data_valid_i  in  1  AD/CT block present on datapath input
data_ready_o  out  1  FSM accepts block this cycle
tag_match_i  in  1  datapath tag-equality result
data_sel_o  out  1  1 = state mux selects IV||K||N load, 0 = round output
en_reg_state_o  out  1  state register write enable
en_xor_key_o  out  1  XOR 0^*||K into state (pre-final)
en_xor_key_end_o  out  1  XOR K into low state bits (post-perm)
en_xor_lsb_o  out  1  domain-separation XOR of 1 into LSB
en_xor_data_o  out  1  XOR input block into x0
en_replace_o  out  1  load x0 with ciphertext block
en_plain_o  out  1  capture plaintext = x0 XOR ct
en_tag_cmp_o  out  1  compare strobe
round_idx_o  out  CNT_W  round-constant index
block_idx_o  out  CNT_W  current CT block, 0..NB_CT-1
plain_valid_o  out  1  one-cycle pulse, plaintext register valid
busy_o  out  1  FSM not in IDLE/DONE
done_o  out  1  high in DONE
auth_ok_o  out  1  registered tag-match result, valid while done_o
auth_fail_o  out  1  complement of auth_ok_o while done_o

Behaviour:
- All control outputs are Moore decodes of registered state and counters. There is no combinational input-to-output path.
- Reset state is IDLE. All outputs reset to 0, and the counters reset to 0.
- State sequence:
  - IDLE: -start_i-> LOAD.
  - LOAD (data_sel_o=1, en_reg_state_o=1; 1 cycle) -> INIT_PERM.
  - INIT_PERM (ROUNDS_A cycles, en_reg_state_o=1) -> INIT_KEY.
  - INIT_KEY (en_xor_key_end_o, en_reg_state_o) -> AD_WAIT.
  - AD_WAIT (data_ready_o=1): on data_valid_i -> AD_ABSORB.
  - AD_ABSORB (en_xor_data_o, en_reg_state_o) -> AD_PERM.
  - AD_PERM (ROUNDS_B cycles) -> DOM_SEP.
  - DOM_SEP (en_xor_lsb_o, en_reg_state_o) -> CT_WAIT.
  - CT_WAIT (data_ready_o): on data_valid_i -> CT_ABSORB.
  - CT_ABSORB (en_plain_o, en_replace_o, en_reg_state_o):
    - if block_idx_o < NB_CT-1 -> CT_PERM;
    - else -> FIN_KEY.
  - CT_PERM (ROUNDS_B cycles) -> CT_WAIT, with block_idx_o incremented.
  - FIN_KEY (en_xor_key_o, en_reg_state_o) -> FIN_PERM.
  - FIN_PERM (ROUNDS_A cycles) -> FIN_KEY2.
  - FIN_KEY2 (en_xor_key_end_o, en_reg_state_o) -> TAG_CMP.
  - TAG_CMP (en_tag_cmp_o; auth flags registered from tag_match_i at exit edge) -> DONE.
- round_idx_o:
  - p^a counts 0..ROUNDS_A-1;
  - p^b counts 12-ROUNDS_B..11;
  - 0 outside permutation states.
- block_idx_o: cleared at LOAD, incremented only on CT_PERM exit, and never wraps.
- data_ready_o is high only in the two WAIT states. The handshake completes on the edge where valid and ready are both high. A WAIT state holds with all enables 0 while data_valid_i is low.
- plain_valid_o is high exactly one cycle, the cycle after each CT_ABSORB.
- DONE behaviour:
  - done_o=1, busy_o=0, and the auth flags hold.
  - start_i -> LOAD, clearing the auth flags on entry to LOAD.
  - Otherwise the FSM stays in DONE.
- start_i is ignored in every busy state.
- abort_i in any state -> IDLE next edge, clearing the counters and auth flags. abort_i together with start_i -> IDLE.
- Async reset mid-message -> IDLE immediately. No partial state is retained.
- Latency with data_valid_i held high and NB_CT=3: done_o rises 56 edges after the edge sampling start_i. In general: 14 + 9 + 8*(NB_CT-1) + 2 + 15.

Decomposition:
- ascon_pkg holds:
  - typedef enum dec_state_t (16 states above);
  - ROUNDS_A/ROUNDS_B defaults;
  - PB_START_IDX=12-ROUNDS_B.
- One sub-module, ascon_round_ctr: load start index, count up, assert last_o at index 11. It is shared by the permutation states.

Test Plan:
- Nominal, data_valid_i tied 1, tag_match_i=1 in TAG_CMP:
  - done_o rises at edge +56;
  - auth_ok_o=1, auth_fail_o=0;
  - en_plain_o pulses 3 times at edges +24, +32, +40;
  - plain_valid_o follows each by 1 cycle.
- Round indexing:
  - INIT_PERM shows round_idx_o 0..11;
  - each AD/CT_PERM shows 6..11;
  - enables are mutually exclusive per cycle;
  - en_reg_state_o=1 in every non-WAIT busy state.
- Backpressure: data_valid_i low for 5 cycles in the second CT_WAIT -> FSM holds, all enables 0, data_ready_o=1, and done_o is delayed to edge +61.
- Tag mismatch: tag_match_i=0 at TAG_CMP -> auth_fail_o=1, auth_ok_o=0 in DONE. A subsequent start_i clears both flags in LOAD.
- Abort:
  - abort_i at cycle 30 together with start_i -> IDLE next edge, outputs 0, block_idx_o=0;
  - a new start then completes normally in 56.
- Async reset: resetb_i pulsed low during FIN_PERM -> all outputs 0 immediately; the FSM stays in IDLE after release until start_i.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON-128 decryption controller.
// Round indices are aligned so every permutation finishes on index LAST_RND_IDX.
package ascon_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT_PERM,
    ST_INIT_KEY,
    ST_AD_WAIT,
    ST_AD_ABSORB,
    ST_AD_PERM,
    ST_DOM_SEP,
    ST_CT_WAIT,
    ST_CT_ABSORB,
    ST_CT_PERM,
    ST_FIN_KEY,
    ST_FIN_PERM,
    ST_FIN_KEY2,
    ST_TAG_CMP,
    ST_DONE
  } dec_state_t;

  localparam int DEF_ROUNDS_A = 12;
  localparam int DEF_ROUNDS_B = 6;
  localparam int LAST_RND_IDX = 11;

  function automatic int rnd_start_idx(input int rounds);
    return LAST_RND_IDX + 1 - rounds;
  endfunction

  localparam int PB_START_IDX = rnd_start_idx(DEF_ROUNDS_B);

endpackage

// File: rtl/ascon_round_ctr.sv
// Round-constant index counter shared by all permutation phases.
// Loads a start index, counts up, and flags the final round.
module ascon_round_ctr #(
  parameter int CNT_W    = 4,
  parameter int LAST_IDX = 11
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] start_idx,
  input  logic             inc,
  output logic [CNT_W-1:0] idx,
  output logic             last_o
);

  assign last_o = (idx == CNT_W'(LAST_IDX));

  // Parks on the last index so a stray inc never wraps into a bogus constant.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i)          idx <= '0;
    else if (clear)         idx <= '0;
    else if (load)          idx <= start_idx;
    else if (inc && !last_o) idx <= idx + 1'b1;
  end

endmodule

// File: rtl/ascon_decrypt_fsm.sv
// ASCON-128 decryption controller: sequences init, AD, ciphertext blocks and
// tag check, driving Moore-decoded enables for the shared datapath.
module ascon_decrypt_fsm
  import ascon_pkg::*;
#(
  parameter int NB_CT    = 3,
  parameter int ROUNDS_A = DEF_ROUNDS_A,
  parameter int ROUNDS_B = DEF_ROUNDS_B,
  parameter int CNT_W    = 4
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  input  logic             tag_match_i,
  output logic             data_sel_o,
  output logic             en_reg_state_o,
  output logic             en_xor_key_o,
  output logic             en_xor_key_end_o,
  output logic             en_xor_lsb_o,
  output logic             en_xor_data_o,
  output logic             en_replace_o,
  output logic             en_plain_o,
  output logic             en_tag_cmp_o,
  output logic [CNT_W-1:0] round_idx_o,
  output logic [CNT_W-1:0] block_idx_o,
  output logic             plain_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             auth_ok_o,
  output logic             auth_fail_o
);

  localparam logic [CNT_W-1:0] PA_START = CNT_W'(rnd_start_idx(ROUNDS_A));
  localparam logic [CNT_W-1:0] PB_START = CNT_W'(rnd_start_idx(ROUNDS_B));
  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NB_CT - 1);

  dec_state_t       state, state_nxt;
  logic [CNT_W-1:0] rnd_cnt, rnd_start, blk_cnt;
  logic             rnd_last, rnd_clear, rnd_load, rnd_inc;
  logic             auth_ok_q, plain_vld_q, in_perm;

  ascon_round_ctr #(
    .CNT_W    (CNT_W),
    .LAST_IDX (LAST_RND_IDX)
  ) u_round_ctr (
    .clock_i   (clock_i),
    .resetb_i  (resetb_i),
    .clear     (rnd_clear),
    .load      (rnd_load),
    .start_idx (rnd_start),
    .inc       (rnd_inc),
    .idx       (rnd_cnt),
    .last_o    (rnd_last)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rnd_clear = 1'b0;
    rnd_load  = 1'b0;
    rnd_start = PB_START;
    rnd_inc   = 1'b0;
    case (state)
      ST_IDLE:      if (start_i) state_nxt = ST_LOAD;
      ST_LOAD:      begin state_nxt = ST_INIT_PERM; rnd_load = 1'b1; rnd_start = PA_START; end
      ST_INIT_PERM: begin rnd_inc = 1'b1; if (rnd_last) state_nxt = ST_INIT_KEY; end
      ST_INIT_KEY:  state_nxt = ST_AD_WAIT;
      ST_AD_WAIT:   if (data_valid_i) state_nxt = ST_AD_ABSORB;
      ST_AD_ABSORB: begin state_nxt = ST_AD_PERM; rnd_load = 1'b1; end
      ST_AD_PERM:   begin rnd_inc = 1'b1; if (rnd_last) state_nxt = ST_DOM_SEP; end
      ST_DOM_SEP:   state_nxt = ST_CT_WAIT;
      ST_CT_WAIT:   if (data_valid_i) state_nxt = ST_CT_ABSORB;
      // The last (padded) block skips p^b and goes straight to finalization.
      ST_CT_ABSORB: begin
        if (blk_cnt < LAST_BLK) begin
          state_nxt = ST_CT_PERM;
          rnd_load  = 1'b1;
        end else begin
          state_nxt = ST_FIN_KEY;
        end
      end
      ST_CT_PERM:   begin rnd_inc = 1'b1; if (rnd_last) state_nxt = ST_CT_WAIT; end
      ST_FIN_KEY:   begin state_nxt = ST_FIN_PERM; rnd_load = 1'b1; rnd_start = PA_START; end
      ST_FIN_PERM:  begin rnd_inc = 1'b1; if (rnd_last) state_nxt = ST_FIN_KEY2; end
      ST_FIN_KEY2:  state_nxt = ST_TAG_CMP;
      ST_TAG_CMP:   state_nxt = ST_DONE;
      ST_DONE:      if (start_i) state_nxt = ST_LOAD;
      default:      state_nxt = ST_IDLE;
    endcase
    if (abort_i) begin
      state_nxt = ST_IDLE;
      rnd_clear = 1'b1;
    end
  end

  // Block index and auth flag are cleared on entry to LOAD so LOAD already shows 0.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      blk_cnt     <= '0;
      auth_ok_q   <= 1'b0;
      plain_vld_q <= 1'b0;
    end else begin
      plain_vld_q <= (state == ST_CT_ABSORB) && !abort_i;
      if (abort_i || state_nxt == ST_LOAD) begin
        blk_cnt   <= '0;
        auth_ok_q <= 1'b0;
      end else begin
        if (state == ST_CT_PERM && rnd_last && blk_cnt != LAST_BLK) blk_cnt <= blk_cnt + 1'b1;
        if (state == ST_TAG_CMP) auth_ok_q <= tag_match_i;
      end
    end
  end

  assign in_perm = (state == ST_INIT_PERM) || (state == ST_AD_PERM) ||
                   (state == ST_CT_PERM)   || (state == ST_FIN_PERM);

  assign data_ready_o     = (state == ST_AD_WAIT) || (state == ST_CT_WAIT);
  assign busy_o           = (state != ST_IDLE) && (state != ST_DONE);
  assign done_o           = (state == ST_DONE);
  assign en_reg_state_o   = busy_o && !data_ready_o;
  assign data_sel_o       = (state == ST_LOAD);
  assign en_xor_key_o     = (state == ST_FIN_KEY);
  assign en_xor_key_end_o = (state == ST_INIT_KEY) || (state == ST_FIN_KEY2);
  assign en_xor_lsb_o     = (state == ST_DOM_SEP);
  assign en_xor_data_o    = (state == ST_AD_ABSORB);
  assign en_replace_o     = (state == ST_CT_ABSORB);
  assign en_plain_o       = (state == ST_CT_ABSORB);
  assign en_tag_cmp_o     = (state == ST_TAG_CMP);
  assign round_idx_o      = in_perm ? rnd_cnt : '0;
  assign block_idx_o      = blk_cnt;
  assign plain_valid_o    = plain_vld_q;
  assign auth_ok_o        = done_o && auth_ok_q;
  assign auth_fail_o      = done_o && !auth_ok_q;

endmodule

// File: tb/tb_ascon_decrypt_fsm.sv
// Directed bench for ascon_decrypt_fsm: table of message scenarios plus
// hand-written abort and asynchronous-reset sequences.
module tb_ascon_decrypt_fsm;

  localparam int CNT_W = 4;
  localparam logic [31:0] EXP_LOAD = (32'd1 << 21) | (32'd1 << 20) | (32'd1 << 3);

  logic clock_i = 1'b0;
  logic resetb_i = 1'b0;
  logic start_i = 1'b0, abort_i = 1'b0, data_valid_i = 1'b0, tag_match_i = 1'b0;
  logic data_ready_o, data_sel_o, en_reg_state_o, en_xor_key_o, en_xor_key_end_o;
  logic en_xor_lsb_o, en_xor_data_o, en_replace_o, en_plain_o, en_tag_cmp_o;
  logic [CNT_W-1:0] round_idx_o, block_idx_o;
  logic plain_valid_o, busy_o, done_o, auth_ok_o, auth_fail_o;

  always #5 clock_i = ~clock_i;

  ascon_decrypt_fsm #(.NB_CT(3), .ROUNDS_A(12), .ROUNDS_B(6), .CNT_W(CNT_W)) dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .abort_i(abort_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .tag_match_i(tag_match_i),
    .data_sel_o(data_sel_o), .en_reg_state_o(en_reg_state_o), .en_xor_key_o(en_xor_key_o),
    .en_xor_key_end_o(en_xor_key_end_o), .en_xor_lsb_o(en_xor_lsb_o),
    .en_xor_data_o(en_xor_data_o), .en_replace_o(en_replace_o), .en_plain_o(en_plain_o),
    .en_tag_cmp_o(en_tag_cmp_o), .round_idx_o(round_idx_o), .block_idx_o(block_idx_o),
    .plain_valid_o(plain_valid_o), .busy_o(busy_o), .done_o(done_o),
    .auth_ok_o(auth_ok_o), .auth_fail_o(auth_fail_o)
  );

  typedef struct {
    int bp_wait;  // which WAIT visit stalls (0 = AD_WAIT, 1..3 = CT_WAITs, -1 none)
    int bp_cyc;
    bit tag;
    int done_at;
    bit ok;
    int p0, p1, p2;
    int ready;
  } vec_t;

  vec_t vecs[5];
  int n_chk = 0, n_fail = 0;

  int r_done, r_ok, r_fail, r_np, r_npv, r_ready;
  int r_plain[3], r_pv[3];
  int e_excl, e_reg, e_wait, e_rnd, e_blk, e_bsy;
  logic [31:0] r_load;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {9'd0, data_ready_o, data_sel_o, en_reg_state_o, en_xor_key_o, en_xor_key_end_o,
            en_xor_lsb_o, en_xor_data_o, en_replace_o, en_plain_o, en_tag_cmp_o,
            round_idx_o, block_idx_o, plain_valid_o, busy_o, done_o, auth_ok_o, auth_fail_o};
  endfunction

  // Expected nominal trace, edges counted from the edge that samples start_i.
  function automatic logic [CNT_W-1:0] exp_round(input int k);
    if (k >= 1 && k <= 12)  return CNT_W'(k - 1);
    if (k >= 16 && k <= 21) return CNT_W'(k - 10);
    if (k >= 25 && k <= 30) return CNT_W'(k - 19);
    if (k >= 33 && k <= 38) return CNT_W'(k - 27);
    if (k >= 42 && k <= 53) return CNT_W'(k - 42);
    return '0;
  endfunction

  function automatic logic [CNT_W-1:0] exp_blk(input int k);
    if (k <= 30) return CNT_W'(0);
    if (k <= 38) return CNT_W'(1);
    return CNT_W'(2);
  endfunction

  task automatic run_msg(input int bp_wait, input int bp_cyc, input bit tag, input int stop_at);
    int waits, stalls;
    logic prev_ready;
    waits = -1; stalls = 0; prev_ready = 1'b0;
    r_done = -1; r_ok = -1; r_fail = -1; r_np = 0; r_npv = 0; r_ready = 0;
    for (int i = 0; i < 3; i++) begin r_plain[i] = -1; r_pv[i] = -1; end
    e_excl = 0; e_reg = 0; e_wait = 0; e_rnd = 0; e_blk = 0; e_bsy = 0;
    data_valid_i = 1'b1;
    tag_match_i  = !tag;
    start_i      = 1'b1;
    step();
    start_i = 1'b0;
    r_load = all_outs();
    for (int k = 1; k <= 200; k++) begin
      step();
      if (en_plain_o) begin if (r_np < 3) r_plain[r_np] = k; r_np++; end
      if (plain_valid_o) begin if (r_npv < 3) r_pv[r_npv] = k; r_npv++; end
      if ($countones({data_sel_o, en_xor_key_o, en_xor_key_end_o, en_xor_lsb_o, en_xor_data_o,
                      en_plain_o | en_replace_o, en_tag_cmp_o}) > 1 || en_plain_o != en_replace_o)
        e_excl++;
      if (en_reg_state_o !== (busy_o && !data_ready_o)) e_reg++;
      if (data_ready_o) begin
        r_ready++;
        if ({data_sel_o, en_reg_state_o, en_xor_key_o, en_xor_key_end_o, en_xor_lsb_o,
             en_xor_data_o, en_replace_o, en_plain_o, en_tag_cmp_o} != 9'd0 || !busy_o)
          e_wait++;
      end
      if (stop_at == 0 && bp_cyc == 0) begin
        if (round_idx_o !== exp_round(k)) e_rnd++;
        if (block_idx_o !== exp_blk(k)) e_blk++;
        if (busy_o !== (k <= 55)) e_bsy++;
      end
      if (done_o) begin
        r_done = k; r_ok = auth_ok_o; r_fail = auth_fail_o;
        break;
      end
      if (k == stop_at) break;
      if (data_ready_o && !prev_ready) waits++;
      prev_ready   = data_ready_o;
      data_valid_i = !(data_ready_o && waits == bp_wait && stalls < bp_cyc);
      if (!data_valid_i) stalls++;
      tag_match_i = en_tag_cmp_o ? tag : !tag;
    end
  endtask

  initial begin
    vecs[0] = '{bp_wait: -1, bp_cyc: 0, tag: 1'b1, done_at: 56, ok: 1'b1, p0: 24, p1: 32, p2: 40, ready: 4};
    vecs[1] = '{bp_wait:  2, bp_cyc: 5, tag: 1'b1, done_at: 61, ok: 1'b1, p0: 24, p1: 37, p2: 45, ready: 9};
    vecs[2] = '{bp_wait: -1, bp_cyc: 0, tag: 1'b0, done_at: 56, ok: 1'b0, p0: 24, p1: 32, p2: 40, ready: 4};
    vecs[3] = '{bp_wait:  0, bp_cyc: 3, tag: 1'b1, done_at: 59, ok: 1'b1, p0: 27, p1: 35, p2: 43, ready: 7};
    vecs[4] = '{bp_wait:  3, bp_cyc: 2, tag: 1'b0, done_at: 58, ok: 1'b0, p0: 24, p1: 32, p2: 42, ready: 6};

    // Reset state, then confirm the FSM idles without start_i.
    #12;
    chk("reset_outs", all_outs(), 32'd0);
    #10 resetb_i = 1'b1;
    step(); step();
    chk("idle_after_reset", all_outs(), 32'd0);

    foreach (vecs[v]) begin
      run_msg(vecs[v].bp_wait, vecs[v].bp_cyc, vecs[v].tag, 0);
      chk($sformatf("v%0d_load_outs", v), r_load, EXP_LOAD);
      chk($sformatf("v%0d_done_edge", v), r_done, vecs[v].done_at);
      chk($sformatf("v%0d_auth_ok", v), r_ok, vecs[v].ok);
      chk($sformatf("v%0d_auth_fail", v), r_fail, !vecs[v].ok);
      chk($sformatf("v%0d_plain_count", v), r_np, 3);
      chk($sformatf("v%0d_plain0", v), r_plain[0], vecs[v].p0);
      chk($sformatf("v%0d_plain1", v), r_plain[1], vecs[v].p1);
      chk($sformatf("v%0d_plain2", v), r_plain[2], vecs[v].p2);
      chk($sformatf("v%0d_pvalid0", v), r_pv[0], vecs[v].p0 + 1);
      chk($sformatf("v%0d_pvalid1", v), r_pv[1], vecs[v].p1 + 1);
      chk($sformatf("v%0d_pvalid2", v), r_pv[2], vecs[v].p2 + 1);
      chk($sformatf("v%0d_pvalid_count", v), r_npv, 3);
      chk($sformatf("v%0d_ready_cycles", v), r_ready, vecs[v].ready);
      chk($sformatf("v%0d_enable_exclusive_errs", v), e_excl, 0);
      chk($sformatf("v%0d_reg_state_errs", v), e_reg, 0);
      chk($sformatf("v%0d_wait_hold_errs", v), e_wait, 0);
      if (vecs[v].bp_cyc == 0) begin
        chk($sformatf("v%0d_round_trace_errs", v), e_rnd, 0);
        chk($sformatf("v%0d_block_trace_errs", v), e_blk, 0);
        chk($sformatf("v%0d_busy_trace_errs", v), e_bsy, 0);
      end
      step(); step(); step();
      chk($sformatf("v%0d_done_hold", v), {done_o, busy_o, auth_ok_o, auth_fail_o},
          {1'b1, 1'b0, vecs[v].ok, !vecs[v].ok});
    end

    // Abort together with start at cycle 30.
    run_msg(-1, 0, 1'b1, 29);
    abort_i = 1'b1; start_i = 1'b1;
    step();
    abort_i = 1'b0; start_i = 1'b0;
    chk("abort30_outs", all_outs(), 32'd0);
    step(); step(); step();
    chk("abort30_stays_idle", all_outs(), 32'd0);

    // Abort once block_idx_o has advanced.
    run_msg(-1, 0, 1'b1, 35);
    chk("pre_abort_block_idx", block_idx_o, 32'd1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort35_outs", all_outs(), 32'd0);

    run_msg(-1, 0, 1'b1, 0);
    chk("after_abort_done_edge", r_done, 56);
    chk("after_abort_auth_ok", r_ok, 1);

    // Asynchronous reset in the middle of FIN_PERM.
    run_msg(-1, 0, 1'b1, 45);
    chk("pre_reset_busy", {busy_o, round_idx_o}, {1'b1, CNT_W'(3)});
    #2 resetb_i = 1'b0;
    #1;
    chk("async_reset_outs", all_outs(), 32'd0);
    #3 resetb_i = 1'b1;
    step(); step(); step();
    chk("after_reset_idle", all_outs(), 32'd0);
    run_msg(-1, 0, 1'b1, 0);
    chk("after_reset_done_edge", r_done, 56);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule
